qsign_conv_pipe: RTL and testbench
==================================

QSIGN_CONV_PIPE -- requirements
Module: qsign_conv_pipe

Interface
REQ-001 Parameter: N, 32, total word width in bits, including the sign bit.
REQ-002 Parameter: Q, 15, fractional bits; carried through unchanged and never used to alter bit positions.
REQ-003 Parameter: CW, 8, width of the overflow event counter.
REQ-004 Port: i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port: i_rst  in  1  synchronous, active-high reset.
REQ-006 Port: i_valid  in  1  input word present.
REQ-007 Port: o_ready  out  1  block accepts input this cycle.
REQ-008 Port: i_mode  in  1  0 = sign-magnitude to two's complement (SM2TC); 1 = two's complement to sign-magnitude (TC2SM); sampled with the input word.
REQ-009 Port: i_data  in  N  input word.
REQ-010 Port: o_valid  out  1  output word present.
REQ-011 Port: i_ready  in  1  downstream accepts output.
REQ-012 Port: o_data  out  N  converted word.
REQ-013 Port: o_overflow  out  1  unrepresentable input; qualified by o_valid.
REQ-014 Port: o_negzero  out  1  SM negative-zero input; qualified by o_valid.
REQ-015 Port: i_clr  in  1  synchronous clear of the overflow counter.
REQ-016 Port: o_ovf_count  out  CW  saturating overflow event count.

Function
REQ-017 The block SHALL be a 2-stage pipeline: S1 captures the input and computes magnitude, inversion and special-case flags; S2 applies the +1 increment and drives the outputs.
REQ-018 Latency SHALL be 2 cycles from an accepted input (i_valid && o_ready) to o_valid when i_ready is held high; throughput SHALL be 1 word per cycle.
REQ-019 A stage SHALL advance when it holds valid data and the next stage is empty or advancing; o_ready = !S1_valid || S1 advancing; the S2 hold condition is o_valid && !i_ready.
REQ-020 While o_valid && !i_ready, o_data, o_overflow and o_negzero SHALL hold stable; no word SHALL be dropped, duplicated or reordered.
REQ-021 SM2TC, sign=0: o_data = i_data.
REQ-022 SM2TC, sign=1, magnitude nonzero: o_data = (~{1'b0, mag}) + 1.
REQ-023 SM2TC, sign=1, magnitude zero: o_data = 0 and o_negzero = 1.
REQ-024 TC2SM, MSB=0: o_data = i_data.
REQ-025 TC2SM, MSB=1, word not 1 followed by all zeros: o_data = {1, ((~i_data)+1)[N-2:0]}.
REQ-026 TC2SM, word = 1 followed by all zeros (minimum value): o_overflow = 1; o_data is set per REQ-031/REQ-032.
REQ-027 o_overflow and o_negzero SHALL be 0 in every case not named in REQ-023 and REQ-026.
REQ-028 o_ovf_count SHALL increment by 1 on each output handshake (o_valid && i_ready) with o_overflow = 1, and SHALL saturate at all ones.
REQ-029 If i_clr and a counting handshake occur in the same cycle, i_clr SHALL win and the count SHALL become 0.

Reset
REQ-030 While i_rst = 1, the block SHALL clear all stage-valid bits, o_valid, o_data, o_overflow, o_negzero and o_ovf_count to 0, and drive o_ready = 0; in-flight words are discarded; o_ready SHALL return to 1 on the first cycle after reset deasserts.

Configuration
REQ-031 With macro QSIGN_CONV_SAT_EN defined, the TC2SM minimum-value input SHALL saturate to o_data = {1, all ones} (most negative representable SM value).
REQ-032 With QSIGN_CONV_SAT_EN undefined, the TC2SM minimum-value input SHALL wrap to o_data = {1, all zeros} (negative zero); o_overflow and counting are identical in both builds.

Verification (N=32, Q=15, CW=8 unless stated)
REQ-033 SM2TC 0x80000001, i_ready=1 -> 2 cycles later o_valid=1, o_data=0xFFFFFFFF, flags 0.
REQ-034 SM2TC 0x80000000 -> o_data=0x00000000, o_negzero=1, o_ovf_count unchanged.
REQ-035 TC2SM 0x80000000 -> o_overflow=1, o_data=0xFFFFFFFF (SAT build) or 0x80000000 (non-SAT build), o_ovf_count 0->1.
REQ-036 Stream 4 words back-to-back, i_ready low for cycles 2-4 -> o_ready falls once both stages are full, o_data holds, all 4 words emerge in order with none lost.
REQ-037 CW=2, 5 overflow handshakes, then i_clr concurrent with a 6th -> count 1,2,3,3,3, then 0.
REQ-038 i_rst asserted with 2 words in flight -> next cycle o_valid=0, o_data=0, count=0; following cycle o_ready=1.

Source files
------------

// File: rtl/qsign_conv_pipe.sv
// Two-stage sign-magnitude <-> two's complement converter with valid/ready flow control.
// Build option: define QSIGN_CONV_SAT_EN to saturate the TC2SM minimum value instead of wrapping to -0.
module qsign_conv_pipe #(
  parameter int unsigned N  = 32,
  parameter int unsigned Q  = 15,
  parameter int unsigned CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_mode,
  input  logic [N-1:0]  i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [N-1:0]  o_data,
  output logic          o_overflow,
  output logic          o_negzero,
  input  logic          i_clr,
  output logic [CW-1:0] o_ovf_count
);

  // Q only annotates the fixed-point format; bit positions never depend on it.
  if (Q >= N) begin : g_q_range
    $error("qsign_conv_pipe: Q must be smaller than N");
  end

  logic         s1_valid;
  logic [N-1:0] s1_val;
  logic         s1_inc;
  logic         s1_ovf;
  logic         s1_nz;

  logic [N-1:0] s1_val_d;
  logic         s1_inc_d;
  logic         s1_ovf_d;
  logic         s1_nz_d;
  logic         mag_zero;
  logic         s2_adv;

  assign s2_adv   = !o_valid || i_ready;
  assign o_ready  = !i_rst && (!s1_valid || s2_adv);
  assign mag_zero = (i_data[N-2:0] == '0);

  // Stage 1: inversion and special cases; the +1 is deferred to stage 2 via s1_inc.
  always_comb begin
    s1_val_d = i_data;
    s1_inc_d = 1'b0;
    s1_ovf_d = 1'b0;
    s1_nz_d  = 1'b0;
    if (i_data[N-1]) begin
      if (!i_mode) begin
        if (mag_zero) begin
          s1_val_d = '0;
          s1_nz_d  = 1'b1;
        end else begin
          s1_val_d = ~{1'b0, i_data[N-2:0]};
          s1_inc_d = 1'b1;
        end
      end else begin
        if (mag_zero) begin
          s1_ovf_d = 1'b1;
`ifdef QSIGN_CONV_SAT_EN
          s1_val_d = '1;
`else
          s1_val_d = {1'b1, {(N-1){1'b0}}};
`endif
        end else begin
          // Low bits of ~x are never all ones here, so the +1 cannot disturb the sign bit.
          s1_val_d = {1'b1, ~i_data[N-2:0]};
          s1_inc_d = 1'b1;
        end
      end
    end
  end

  // Pipeline registers for both stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid   <= 1'b0;
      s1_val     <= '0;
      s1_inc     <= 1'b0;
      s1_ovf     <= 1'b0;
      s1_nz      <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= 1'b0;
      o_negzero  <= 1'b0;
    end else begin
      if (o_ready) begin
        s1_valid <= i_valid;
        if (i_valid) begin
          s1_val <= s1_val_d;
          s1_inc <= s1_inc_d;
          s1_ovf <= s1_ovf_d;
          s1_nz  <= s1_nz_d;
        end
      end
      if (s2_adv) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_data     <= s1_val + N'(s1_inc);
          o_overflow <= s1_ovf;
          o_negzero  <= s1_nz;
        end
      end
    end
  end

  // Saturating overflow event counter; clear wins over a concurrent count.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_ovf_count <= '0;
    end else if (o_valid && i_ready && o_overflow && (o_ovf_count != {CW{1'b1}})) begin
      o_ovf_count <= o_ovf_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_qsign_conv_pipe.sv
// Self-checking bench for qsign_conv_pipe: directed vectors, back-pressure, counter and random stream.
module tb_qsign_conv_pipe;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_mode, i_ready, i_clr;
  logic [31:0] i_data;
  logic        o_ready, o_valid, o_overflow, o_negzero;
  logic [31:0] o_data;
  logic [7:0]  o_ovf_count;
  logic        r2, v2, ov2, nz2;
  logic [31:0] d2;
  logic [1:0]  cnt2;

  int tests  = 0;
  int failed = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  qsign_conv_pipe #(.N(32), .Q(15), .CW(8)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_overflow(o_overflow), .o_negzero(o_negzero), .i_clr(i_clr), .o_ovf_count(o_ovf_count)
  );

  qsign_conv_pipe #(.N(32), .Q(15), .CW(2)) u_dut2 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(r2), .i_mode(i_mode),
    .i_data(i_data), .o_valid(v2), .i_ready(i_ready), .o_data(d2),
    .o_overflow(ov2), .o_negzero(nz2), .i_clr(i_clr), .o_ovf_count(cnt2)
  );

  // Reference conversion by plain negation; result is {overflow, negzero, data}.
  function automatic logic [33:0] model(input logic mode, input logic [31:0] d);
    logic [31:0] r;
    logic [31:0] neg;
    logic ovf;
    logic nz;
    ovf = 1'b0;
    nz  = 1'b0;
    r   = d;
    if (!mode) begin
      if (d[31]) begin
        if (d[30:0] == 31'd0) begin
          r  = 32'd0;
          nz = 1'b1;
        end else begin
          r = 32'd0 - {1'b0, d[30:0]};
        end
      end
    end else if (d[31]) begin
      if (d == 32'h8000_0000) begin
        ovf = 1'b1;
`ifdef QSIGN_CONV_SAT_EN
        r = 32'hFFFF_FFFF;
`else
        r = 32'h8000_0000;
`endif
      end else begin
        neg = 32'd0 - d;
        r   = {1'b1, neg[30:0]};
      end
    end
    return {ovf, nz, r};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h0000_0000;
      2: return 32'h8000_0001;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; i_ready = 1'b1; i_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_data !== 32'd0 || o_overflow !== 1'b0 ||
        o_negzero !== 1'b0 || o_ovf_count !== 8'd0) begin
      failed++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h ovf=%b nz=%b cnt=%0d, expected 0,0,0,0,0,0",
               o_ready, o_valid, o_data, o_overflow, o_negzero, o_ovf_count);
    end
    @(negedge clk); i_rst = 1'b0;
    #1;
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", o_ready, o_valid);
    end
  endtask

  task automatic test_directed();
    logic        tm[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] td[5]  = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0005};
`ifdef QSIGN_CONV_SAT_EN
    logic [31:0] te[5]  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0005};
`else
    logic [31:0] te[5]  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h8000_0001, 32'h0000_0005};
`endif
    logic [1:0]  tf[5]  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [7:0]  tc[5]  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    @(negedge clk); i_clr = 1'b1;
    @(negedge clk); i_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_valid = 1'b1; i_mode = tm[k]; i_data = td[k]; i_ready = 1'b1;
      @(negedge clk); i_valid = 1'b0;
      #1;
      tests++;
      if (o_valid !== 1'b0) begin
        failed++;
        $display("FAIL dir%0d_early: o_valid=%b after 1 cycle, expected 0", k, o_valid);
      end
      @(negedge clk); #1;
      tests++;
      if (o_valid !== 1'b1 || o_data !== te[k] || {o_overflow, o_negzero} !== tf[k]) begin
        failed++;
        $display("FAIL dir%0d_out: got vld=%b data=%h flags=%b, expected vld=1 data=%h flags=%b",
                 k, o_valid, o_data, {o_overflow, o_negzero}, te[k], tf[k]);
      end
      @(negedge clk); #1;
      tests++;
      if (o_ovf_count !== tc[k] || o_valid !== 1'b0) begin
        failed++;
        $display("FAIL dir%0d_cnt: got cnt=%0d vld=%b, expected cnt=%0d vld=0", k, o_ovf_count, o_valid, tc[k]);
      end
    end
  endtask

  task automatic test_counter();
    logic [1:0] exp2;
    logic [7:0] exp1;
    @(negedge clk); i_clr = 1'b1;
    @(negedge clk); i_clr = 1'b0;
    #1;
    tests++;
    if (o_ovf_count !== 8'd0 || cnt2 !== 2'd0) begin
      failed++;
      $display("FAIL cnt_clear: got %0d/%0d, expected 0/0", o_ovf_count, cnt2);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      i_valid = 1'b1; i_mode = 1'b1; i_data = 32'h8000_0000; i_ready = 1'b1;
      @(negedge clk); i_valid = 1'b0;
      @(negedge clk); i_clr = (k == 6);
      #1;
      tests++;
      if (v2 !== o_valid || d2 !== o_data || ov2 !== o_overflow || nz2 !== o_negzero || r2 !== o_ready) begin
        failed++;
        $display("FAIL cnt_cw2_path: got vld=%b data=%h, expected vld=%b data=%h", v2, d2, o_valid, o_data);
      end
      @(negedge clk); i_clr = 1'b0;
      #1;
      exp2 = (k == 6) ? 2'd0 : ((k > 3) ? 2'd3 : 2'(k));
      exp1 = (k == 6) ? 8'd0 : 8'(k);
      tests++;
      if (cnt2 !== exp2 || o_ovf_count !== exp1) begin
        failed++;
        $display("FAIL cnt_step%0d: got cw2=%0d cw8=%0d, expected cw2=%0d cw8=%0d", k, cnt2, o_ovf_count, exp2, exp1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    logic [33:0] e;
    exp_q.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      i_valid = (sent < 4); i_mode = 1'($urandom_range(0, 1)); i_data = rnd_word();
      i_ready = !(c >= 2 && c <= 4);
      #1;
      if (c < 6) begin
        tests++;
        if (o_ready !== !(c >= 2 && c <= 4)) begin
          failed++;
          $display("FAIL b2b_ready_c%0d: got %b, expected %b", c, o_ready, !(c >= 2 && c <= 4));
        end
      end
      if (o_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL b2b_extra: got data=%h, expected no word", o_data);
        end else begin
          e = exp_q[0];
          if ({o_overflow, o_negzero, o_data} !== e) begin
            failed++;
            $display("FAIL b2b_data_c%0d: got %h, expected %h", c, {o_overflow, o_negzero, o_data}, e);
          end
        end
      end
      if (o_valid && i_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        got++;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_mode, i_data));
        sent++;
      end
    end
    i_valid = 1'b0;
    tests++;
    if (got !== 4 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL b2b_count: got %0d words, expected 4 (left %0d)", got, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp_cnt = 8'd0;
    logic [33:0] e;
    int accepted = 0;
    exp_q.delete();
    @(negedge clk); i_clr = 1'b1; i_valid = 1'b0;
    @(negedge clk); i_clr = 1'b0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (c < 680) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_ready = ($urandom_range(0, 2) != 0);
      end else begin
        i_valid = 1'b0;
        i_ready = 1'b1;
      end
      i_mode = 1'($urandom_range(0, 1));
      i_data = rnd_word();
      #1;
      tests++;
      if (o_ready !== ((exp_q.size() < 2) || i_ready)) begin
        failed++;
        $display("FAIL rnd_ready_c%0d: got %b, expected %b", c, o_ready, (exp_q.size() < 2) || i_ready);
      end
      if (o_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL rnd_extra_c%0d: got data=%h, expected no word", c, o_data);
        end else begin
          e = exp_q[0];
          if ({o_overflow, o_negzero, o_data} !== e) begin
            failed++;
            $display("FAIL rnd_data_c%0d: got %h, expected %h", c, {o_overflow, o_negzero, o_data}, e);
          end
        end
      end
      tests++;
      if (o_ovf_count !== exp_cnt) begin
        failed++;
        $display("FAIL rnd_count_c%0d: got %0d, expected %0d", c, o_ovf_count, exp_cnt);
      end
      if (o_valid && i_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[33] && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_mode, i_data));
        accepted++;
      end
    end
    tests++;
    if (exp_q.size() != 0 || accepted < 100) begin
      failed++;
      $display("FAIL rnd_drain: got %0d pending / %0d accepted, expected 0 pending / >=100 accepted",
               exp_q.size(), accepted);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk); i_valid = 1'b1; i_mode = 1'b1; i_data = 32'h8000_0000; i_ready = 1'b1;
    @(negedge clk); i_mode = 1'b0; i_data = 32'h0000_0007;
    @(negedge clk); i_valid = 1'b0;
    #1;
    tests++;
    if (o_valid !== 1'b1) begin
      failed++;
      $display("FAIL rst_inflight_pre: o_valid=%b, expected 1", o_valid);
    end
    i_rst = 1'b1;
    #1;
    tests++;
    if (o_ready !== 1'b0) begin
      failed++;
      $display("FAIL rst_ready_low: got %b, expected 0", o_ready);
    end
    @(negedge clk); #1;
    tests++;
    if (o_valid !== 1'b0 || o_data !== 32'd0 || o_ovf_count !== 8'd0 || cnt2 !== 2'd0) begin
      failed++;
      $display("FAIL rst_inflight: got vld=%b data=%h cnt=%0d, expected 0,0,0", o_valid, o_data, o_ovf_count);
    end
    i_rst = 1'b0;
    #1;
    tests++;
    if (o_ready !== 1'b1) begin
      failed++;
      $display("FAIL rst_ready_back: got %b, expected 1", o_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      tests++;
      if (o_valid !== 1'b0) begin
        failed++;
        $display("FAIL rst_ghost%0d: o_valid=%b, expected 0", k, o_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_counter();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
